cordic_fx2fp: RTL and testbench

Sequential fixed-point to IEEE-754 single-precision converter placed directly downstream of the CORDIC cosine core. It takes the core's 32-bit two's-complement fixed-point result and returns the equivalent binary32 float. It uses the same start/done custom-instruction handshake as the core, so the two can be chained or exposed as one custom instruction. Normalisation is iterative, one bit per cycle, so latency depends on the data.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_fx2fp_if.sv | 17 +
 rtl/cordic_fx2fp_pack.sv | 71 +++++++
 rtl/cordic_fx2fp.sv | 109 ++++++++++
 tb/tb_cordic_fx2fp.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg -- shared types and constants for the fixed-point to binary32
// converter that sits behind the CORDIC cosine core.
//   state_t        : converter FSM states
//   FP_*           : binary32 field widths, exponent bias and field positions
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_MANT_W   = 23;
  localparam int FP_EXP_W    = 8;

  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MANT_MSB = 22;
  localparam int FP_MANT_LSB = 0;

endpackage

// File: rtl/cordic_fx2fp_if.sv
// cordic_fx2fp_if -- start/done custom-instruction handshake of the converter.
//   clk_en : clock enable, all converter registers hold while low
//   start  : request, sampled only in IDLE
//   dataa  : signed fixed-point operand
//   result : binary32 result, held until the next completion
//   done   : one-cycle completion pulse
// master drives the request side, slave is the converter.
interface cordic_fx2fp_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;

  modport master (output clk_en, start, dataa, input result, done);
  modport slave  (input clk_en, start, dataa, output result, done);
endinterface

// File: rtl/cordic_fx2fp_pack.sv
// cordic_fx2fp_pack -- combinational packer from the normalised magnitude to
// a binary32 word.
//   sign_i : operand sign
//   pos_i  : bit position the leading one originally occupied
//   mag_i  : normalised magnitude (leading one in bit 31, or zero)
//   word_o : packed binary32 value; +0.0 for a zero magnitude
// Build option: CORDIC_FX2FP_ROUND_EN selects round-to-nearest-even,
// otherwise the mantissa is truncated.
module cordic_fx2fp_pack
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS = 30
) (
  input  logic        sign_i,
  input  logic [4:0]  pos_i,
  input  logic [31:0] mag_i,
  output logic [31:0] word_o
);

  // pos - FRAC_BITS + bias never leaves 96..158 for FRAC_BITS in 0..31
  localparam logic [FP_EXP_W-1:0] EXP_OFS = FP_EXP_W'(FP_EXP_BIAS - FRAC_BITS);

  logic [FP_EXP_W-1:0]  exp_raw;
  logic [FP_MANT_W-1:0] mant_raw;
  logic [FP_EXP_W-1:0]  exp_fin;
  logic [FP_MANT_W-1:0] mant_fin;
  logic                 unused_hidden;

  assign exp_raw       = {3'b000, pos_i} + EXP_OFS;
  assign mant_raw      = mag_i[30:8];
  // bit 31 is the implicit leading one
  assign unused_hidden = mag_i[31];

`ifdef CORDIC_FX2FP_ROUND_EN
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [FP_MANT_W:0]   mant_inc;

  assign guard    = mag_i[7];
  assign sticky   = |mag_i[6:0];
  assign round_up = guard & (sticky | mant_raw[0]);
  assign mant_inc = {1'b0, mant_raw} + {{FP_MANT_W{1'b0}}, 1'b1};

  // a carry out of the mantissa leaves it all-zero and bumps the exponent
  always_comb begin
    exp_fin  = exp_raw;
    mant_fin = mant_raw;
    if (round_up) begin
      mant_fin = mant_inc[FP_MANT_W-1:0];
      exp_fin  = exp_raw + {{(FP_EXP_W-1){1'b0}}, mant_inc[FP_MANT_W]};
    end
  end
`else
  logic unused_round_bits;

  assign unused_round_bits = ^mag_i[7:0];
  assign exp_fin           = exp_raw;
  assign mant_fin          = mant_raw;
`endif

  always_comb begin
    word_o = 32'h0000_0000;
    if (mag_i != 32'h0000_0000) begin
      word_o[FP_SIGN_BIT]              = sign_i;
      word_o[FP_EXP_MSB:FP_EXP_LSB]    = exp_fin;
      word_o[FP_MANT_MSB:FP_MANT_LSB]  = mant_fin;
    end
  end

endmodule

// File: rtl/cordic_fx2fp.sv
// cordic_fx2fp -- sequential 32-bit signed fixed-point to binary32 converter.
//   clock  : system clock, rising edge
//   aclr   : synchronous active-high reset, wins over start and clk_en
//   bus    : start/done handshake (cordic_fx2fp_if.slave)
// Normalisation shifts one bit per enabled cycle, so latency is
// leading-zeros + 2 cycles (2 for a zero operand).
// Build option: CORDIC_FX2FP_ROUND_EN (handled in cordic_fx2fp_pack).
//
// state | meaning
// IDLE  | waiting for start; done pulse is visible here
// NORM  | shifting magnitude left until bit 31 is set or it is zero
// PACK  | registering the packed word and raising done
module cordic_fx2fp
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS = 30
) (
  input  logic            clock,
  input  logic            aclr,
  cordic_fx2fp_if.slave   bus
);

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  pos_q, pos_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic [31:0] packed_word;
  logic        norm_stop;

  assign norm_stop = (mag_q == 32'h0000_0000) || mag_q[31];

  cordic_fx2fp_pack #(
    .FRAC_BITS (FRAC_BITS)
  ) u_pack (
    .sign_i (sign_q),
    .pos_i  (pos_q),
    .mag_i  (mag_q),
    .word_o (packed_word)
  );

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q <= IDLE;
    end else if (bus.clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = NORM;
      NORM:    if (norm_stop) state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mag_d    = mag_q;
    pos_d    = pos_q;
    sign_d   = sign_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d = bus.dataa[31];
          // -0x80000000 wraps to 0x80000000, which is the correct magnitude
          mag_d  = bus.dataa[31] ? (~bus.dataa + 32'd1) : bus.dataa;
          pos_d  = 5'd31;
        end
      end
      NORM: begin
        if (!norm_stop) begin
          mag_d = {mag_q[30:0], 1'b0};
          pos_d = pos_q - 5'd1;
        end
      end
      PACK: begin
        result_d = packed_word;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      mag_q    <= 32'h0000_0000;
      pos_q    <= 5'd0;
      sign_q   <= 1'b0;
      result_q <= 32'h0000_0000;
      done_q   <= 1'b0;
    end else if (bus.clk_en) begin
      mag_q    <= mag_d;
      pos_q    <= pos_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_cordic_fx2fp.sv
module tb_cordic_fx2fp;

  localparam int FRAC = 30;
  localparam int TMO  = 80;

  logic clock;
  logic aclr;
  int   n_checks;
  int   n_err;

  cordic_fx2fp_if bif ();

  cordic_fx2fp #(
    .FRAC_BITS (FRAC)
  ) dut (
    .clock (clock),
    .aclr  (aclr),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: value = (-1)^s * m * 2^-FRAC, expressed as q * 2^(p-23) with
  // q the 24-bit significand obtained by exact integer division.
  function automatic logic [31:0] ref_fp(input logic [31:0] d, output int lat);
    logic            sgn;
    longint unsigned m, num, q, rem, half;
    int              p, e;
    sgn = d[31];
    m   = sgn ? (64'h1_0000_0000 - {32'h0, d}) : {32'h0, d};
    if (m == 0) begin
      lat = 2;
      return 32'h0000_0000;
    end
    p = 31;
    while (m < (64'd1 << p)) p--;
    lat  = (31 - p) + 2;
    num  = m << 23;
    q    = num >> p;
    rem  = num - (q << p);
    half = 0;
`ifdef CORDIC_FX2FP_ROUND_EN
    if (p > 0) begin
      half = 64'd1 << (p - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        p++;
      end
    end
`endif
    e = p - FRAC + 127;
    return {sgn, 8'(e), 23'(q)};
  endfunction

  task automatic start_op(input logic [31:0] d);
    bif.start = 1'b1;
    bif.dataa = d;
    @(posedge clock);
    #1;
    bif.start = 1'b0;
  endtask

  // counts edges after the accepting edge until done is seen
  task automatic wait_done(input int stall_at, input int poke_at, output int cyc);
    cyc = 0;
    while (cyc < TMO) begin
      @(posedge clock);
      #1;
      cyc++;
      if (bif.done) break;
      if (stall_at > 0 && cyc == stall_at) bif.clk_en = 1'b0;
      if (stall_at > 0 && cyc == stall_at + 5) bif.clk_en = 1'b1;
      if (poke_at > 0 && cyc == poke_at) begin
        bif.start = 1'b1;
        bif.dataa = 32'h4000_0000;
      end
      if (poke_at > 0 && cyc == poke_at + 1) bif.start = 1'b0;
    end
    if (!bif.done) begin
      check("timeout", 32'd0, 32'd1);
      cyc = -1;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] d, input int stall_at,
                        input int poke_at, input bit pulse_chk);
    logic [31:0] exp;
    int          lat, cyc;
    exp = ref_fp(d, lat);
    start_op(d);
    wait_done(stall_at, poke_at, cyc);
    check({tag, "_result"}, bif.result, exp);
    check({tag, "_latency"}, 32'(cyc), 32'(lat + ((stall_at > 0) ? 5 : 0)));
    if (pulse_chk) begin
      @(posedge clock);
      #1;
      check({tag, "_done_pulse"}, {31'd0, bif.done}, 32'd0);
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] d;
    n_checks    = 0;
    n_err       = 0;
    aclr        = 1'b1;
    bif.clk_en  = 1'b1;
    bif.start   = 1'b0;
    bif.dataa   = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    aclr = 1'b0;
    check("reset_result", bif.result, 32'h0);
    check("reset_done", {31'd0, bif.done}, 32'd0);

    run_op("one",      32'h4000_0000, 0, 0, 1);
    check("one_const", bif.result, 32'h3F80_0000);
    run_op("neg_one",  32'hC000_0000, 0, 0, 1);
    check("neg_one_const", bif.result, 32'hBF80_0000);
    run_op("half",     32'h2000_0000, 0, 0, 1);
    run_op("zero",     32'h0000_0000, 0, 0, 1);
    run_op("neg_two",  32'h8000_0000, 0, 0, 1);
    check("neg_two_const", bif.result, 32'hC000_0000);
    run_op("lsb",      32'h0000_0001, 0, 0, 1);
    check("lsb_const", bif.result, 32'h3080_0000);
    run_op("allones",  32'h7FFF_FFFF, 0, 0, 1);
`ifdef CORDIC_FX2FP_ROUND_EN
    check("allones_const", bif.result, 32'h4000_0000);
`else
    check("allones_const", bif.result, 32'h3FFF_FFFF);
`endif

    // start pulsed mid-NORM must be ignored
    run_op("ign_start", 32'h0000_0001, 0, 6, 1);

    // back-to-back: second start issued in the done cycle
    run_op("b2b_a", 32'h4000_0000, 0, 0, 0);
    run_op("b2b_b", 32'h0010_0000, 0, 0, 1);

    // clk_en low for 5 cycles mid-NORM
    run_op("stall", 32'h0000_0001, 10, 0, 0);
    // pending done stays high while clk_en is low
    bif.clk_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("done_held", {31'd0, bif.done}, 32'd1);
    bif.clk_en = 1'b1;
    @(posedge clock);
    #1;
    check("done_release", {31'd0, bif.done}, 32'd0);

    // reset two cycles after start aborts the operation
    start_op(32'h0000_0001);
    repeat (2) @(posedge clock);
    #1;
    aclr = 1'b1;
    @(posedge clock);
    #1;
    aclr = 1'b0;
    check("abort_result", bif.result, 32'h0);
    check("abort_done", {31'd0, bif.done}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (bif.done) cnt++;
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    run_op("after_abort", 32'h4000_0000, 0, 0, 1);
    check("after_abort_const", bif.result, 32'h3F80_0000);

    for (int i = 0; i < 40; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = ~d + 32'd1;
      if ($urandom_range(0, 15) == 0) d = 32'h0;
      run_op("rand", d, 0, 0, (i % 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
